// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//
// Clocked stimulus-and-compare stage for a combinational gate under test.
// On start it walks every input vector 0 .. 2^N_IN-1. Each vector is
// driven to the gate under test and to its control model, held for HOLD
// settle cycles, and then the two outputs are compared for one cycle. The
// block reports the number of mismatching vectors, the first failing
// vector and a pass/fail verdict.
//
// Parameters:
//   N_IN  - number of gate inputs; 2^N_IN vectors are swept
//   HOLD  - settle cycles per vector before sampling (minimum 1)
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-high reset
//   start           - single-cycle sweep request (ignored while busy)
//   vec_out         - current stimulus vector (bit 0 = first gate input)
//   dut_s           - output of the gate under test
//   ref_s           - output of the control model
//   busy            - sweep in progress
//   done            - sweep finished, results valid
//   pass            - with done: no mismatches were seen
//   err_count       - number of mismatching vectors (N_IN+1 bits, no wrap)
//   first_err_vec   - vector of the first mismatch
//   first_err_valid - first_err_vec holds a captured vector
//
// Build option:
//   GVC_STOP_ON_ERR_EN - when defined, the first mismatch ends the sweep
//                        immediately with vec_out holding the failing vector.

module gate_vector_checker #(
    parameter int N_IN = 2,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_s,
    input  logic            ref_s,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic            last_vec;

    // Case inequality so that an X or Z from the gate under test is
    // reported as a mismatch rather than silently matching.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        last_vec = (vec_out == VEC_LAST);
        if (dut_s !== ref_s) begin
            mismatch = 1'b1;
        end
        err_next = err_count + (N_IN + 1)'(mismatch);
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= DRIVE;
                        hold_cnt        <= '0;
                        vec_out         <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                SAMPLE: begin
                    // Counter and capture update in the same cycle as the
                    // move to DONE, so done never exposes stale results.
                    err_count <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_vec   <= vec_out;
                        first_err_valid <= 1'b1;
                    end
`ifdef GVC_STOP_ON_ERR_EN
                    if (last_vec || mismatch) begin
`else
                    if (last_vec) begin
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= DRIVE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker (N_IN=2, HOLD=1).
// A behavioural AND is the control model; the gate under test is selected
// per scenario. Expected sweep results are pushed to a scoreboard when a
// sweep is started and popped when the DUT raises done.

module tb_gate_vector_checker;

    localparam int N_IN        = 2;
    localparam int HOLD        = 1;
    localparam int NUM_VEC     = 1 << N_IN;
    localparam int CYC_PER_VEC = HOLD + 1;
    localparam int TIMEOUT     = 64;

    typedef enum int { GOOD, STUCK0, INVERT, XPROP } mode_t;

    typedef struct {
        int             cycles;
        logic [N_IN:0]  err;
        logic [N_IN-1:0] first_vec;
        logic           first_valid;
        logic           pass_v;
        logic [N_IN-1:0] last_vec;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [N_IN-1:0] vec_out;
    logic            dut_s;
    logic            ref_s;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    mode_t mode = GOOD;
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    gate_vector_checker #(.N_IN(N_IN), .HOLD(HOLD)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vec_out         (vec_out),
        .dut_s           (dut_s),
        .ref_s           (ref_s),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    function automatic logic gate_model(mode_t m, logic [N_IN-1:0] v);
        logic n;
        n = ~(v[0] & v[1]);
        case (m)
            GOOD:    return ~(n & n);
            STUCK0:  return 1'b0;
            INVERT:  return n;
            XPROP:   return (v == 2'b01) ? 1'bx : (v[0] & v[1]);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        dut_s = gate_model(mode, vec_out);
        ref_s = vec_out[0] & vec_out[1];
    end

    function automatic exp_t predict(mode_t m);
        exp_t e;
        logic [N_IN-1:0] v;
        logic d;
        logic r;
        e.err = '0;
        e.first_vec = '0;
        e.first_valid = 1'b0;
        e.cycles = NUM_VEC * CYC_PER_VEC;
        e.last_vec = '1;
        for (int i = 0; i < NUM_VEC; i++) begin
            v = N_IN'(i);
            d = gate_model(m, v);
            r = v[0] & v[1];
            if (d !== r) begin
                e.err = e.err + 1'b1;
                if (!e.first_valid) begin
                    e.first_valid = 1'b1;
                    e.first_vec = v;
                end
`ifdef GVC_STOP_ON_ERR_EN
                e.cycles = (i + 1) * CYC_PER_VEC;
                e.last_vec = v;
                break;
`endif
            end
        end
        e.pass_v = (e.err == '0);
        return e;
    endfunction

    task automatic check_all_zero(string name);
        checks++;
        if ({vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid} !== '0) begin
            errors++;
            $display("FAIL %s: outputs vec=%b busy=%b done=%b pass=%b err=%0d fvec=%b fvalid=%b, required all 0",
                     name, vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid);
        end
    endtask

    // Runs one sweep; optionally pulses start at edges 3 and 5 mid-sweep.
    task automatic run_sweep(mode_t m, bit pulse_mid, string name);
        exp_t e;
        int   cycles;
        bit   got;
        mode = m;
        sb.push_back(predict(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || vec_out !== '0 || done !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: busy=%b vec=%b done=%b err=%0d fvalid=%b, required busy=1 vec=00 done=0 err=0 fvalid=0",
                     name, busy, vec_out, done, err_count, first_err_valid);
        end
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done === 1'b1) got = 1'b1;
            start = pulse_mid && !got && (cycles == 2 || cycles == 4);
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles, required at cycle %0d", name, TIMEOUT, e.cycles);
            return;
        end
        if (cycles != e.cycles) begin
            errors++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cycles, e.cycles);
        end
        checks++;
        if (err_count !== e.err) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, e.err);
        end
        checks++;
        if (first_err_valid !== e.first_valid || (e.first_valid && first_err_vec !== e.first_vec)) begin
            errors++;
            $display("FAIL %s_first_err: got valid=%b vec=%b, required valid=%b vec=%b",
                     name, first_err_valid, first_err_vec, e.first_valid, e.first_vec);
        end
        checks++;
        if (pass !== e.pass_v || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_verdict: got pass=%b busy=%b, required pass=%b busy=0", name, pass, busy, e.pass_v);
        end
        checks++;
        if (vec_out !== e.last_vec) begin
            errors++;
            $display("FAIL %s_vec_hold: got vec=%b, required %b", name, vec_out, e.last_vec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_good();
        run_sweep(GOOD, 1'b0, "good");
    endtask

    task automatic test_stuck0();
        run_sweep(STUCK0, 1'b0, "stuck0");
    endtask

    task automatic test_inverted();
        run_sweep(INVERT, 1'b0, "inverted");
    endtask

    task automatic test_xprop();
        run_sweep(XPROP, 1'b0, "xprop");
    endtask

    task automatic test_reset_mid_sweep();
        int  cycles;
        bit  seen;
        mode = INVERT;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (vec_out === 2'b10) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset_wait: vec_out never reached 10 within %0d cycles", TIMEOUT);
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset_async");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(GOOD, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        run_sweep(STUCK0, 1'b1, "start_ignored");
    endtask

    task automatic test_back_to_back();
        run_sweep(INVERT, 1'b0, "b2b_first");
        run_sweep(INVERT, 1'b0, "b2b_second");
        run_sweep(GOOD, 1'b0, "b2b_clean");
    endtask

    initial begin
        test_reset();
        test_good();
        test_stuck0();
        test_inverted();
        test_xprop();
        test_reset_mid_sweep();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Sequential stimulus-and-compare stage that sits directly upstream of a combinational gate under test and its behavioural control model. On `start` it walks every input vector from 0 to 2^N_IN−1, drives it to both, waits a settle window, compares the two outputs, and reports a mismatch count, the first failing vector and a pass/fail verdict. This replaces the hand-written `#1` stimulus sequence and visual `$monitor` inspection with a self-checking, clocked block.

## Interface
- `N_IN`, default 2: number of gate inputs; the block sweeps 2^N_IN vectors.
- `HOLD`, default 1, minimum 1: settle cycles each vector is held before sampling.

- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: single-cycle request to begin a sweep.
- `vec_out` output N_IN: current stimulus vector; bit 0 maps to the first gate input.
- `dut_s` input 1: output of the gate under test.
- `ref_s` input 1: output of the control model.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished, results valid.
- `pass` output 1: high with `done` when `err_count` is 0.
- `err_count` output N_IN+1: number of mismatching vectors.
- `first_err_vec` output N_IN: vector of the first mismatch.
- `first_err_valid` output 1: `first_err_vec` holds a captured value.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and the hold counter is 0.
- **IDLE:** `start=1` clears `err_count`, `first_err_*` and `done`, sets `vec_out=0` and `busy=1`, and moves to DRIVE.
- **DRIVE:** the hold counter counts HOLD cycles. On the last count the FSM moves to SAMPLE.
- **SAMPLE (one cycle):**
  - The compare uses `dut_s !== ref_s`, so X or Z on `dut_s` counts as a mismatch.
  - On a mismatch, `err_count` increments. If `first_err_valid=0`, the block captures `vec_out` into `first_err_vec` and sets `first_err_valid`.
  - If `vec_out` equals all-ones, the FSM moves to DONE. Otherwise `vec_out` increments and the FSM returns to DRIVE.
- **DONE:** `busy=0`, `done=1`, `pass=(err_count==0)`. All results hold. `start=1` begins a new sweep, which behaves like the IDLE start.
- `start` while `busy=1` is ignored.
- `err_count` is N_IN+1 bits wide, so it holds the maximum value 2^N_IN without wrapping.
- `vec_out` never wraps past all-ones; the last vector leads to DONE.
- Mismatch on the final vector: the counter and capture update in the same SAMPLE cycle as the move to DONE, so `done` never shows stale counts.
- `rst` mid-sweep: the block returns to reset values immediately. No partial result is retained.

## Timing
- Cycles per vector: HOLD+1 (HOLD in DRIVE, 1 in SAMPLE).
- `start` sampled at edge 0:
  - `busy=1` and `vec_out=0` are visible after edge 0.
  - `done=1` is visible after edge 2^N_IN·(HOLD+1).
- N_IN=2, HOLD=1: `done` rises 8 cycles after `start`.
- `vec_out` changes only on the SAMPLE→DRIVE edge and is stable for HOLD+1 cycles.
- The DUT must settle within HOLD cycles.

## Configuration
- `GVC_STOP_ON_ERR_EN`
  - Defined: the first mismatch in SAMPLE sends the FSM straight to DONE. `err_count` is then 1, `pass=0`, and `vec_out` holds the failing vector.
  - Undefined: the sweep always covers all 2^N_IN vectors and counts every mismatch.

## Test plan
- **Good DUT:** N_IN=2, HOLD=1, NAND-built AND vs behavioural AND, pulse `start` → `done` after 8 cycles, `err_count=0`, `pass=1`, `first_err_valid=0`.
- **Stuck-at-0 DUT:** `dut_s` tied 0 vs AND control → `err_count=1`, `first_err_vec=2'b11`, `pass=0`.
- **Inverted DUT:** NAND vs AND control → `err_count=4`, `first_err_vec=2'b00`. With `GVC_STOP_ON_ERR_EN`: `done` after 2 cycles, `err_count=1`, `vec_out=2'b00`.
- **Reset mid-sweep:** `rst` asserted while `vec_out=2'b10` → all outputs 0 asynchronously. A following `start` produces a full, clean 8-cycle sweep.
- **Start handling:** `start` pulsed at cycles 3 and 5 of a sweep → ignored, `done` still at cycle 8. `start` in DONE → counts cleared and the sweep repeats.
- **X propagation:** `dut_s` driven X for vector `2'b01` → that vector counts as a mismatch, `err_count=1`, `first_err_vec=2'b01`.
